// File: rtl/polar_pkg.sv
// Shared constants, the atan table and the FSM state type for polar_to_rect.
package polar_pkg;

    localparam int ANGLE_W = 16;
    localparam int ABS_W   = 8;
    localparam int OUT_W   = 9;

    localparam logic signed [ANGLE_W-1:0] PI_Q13      = 16'sd25736;
    localparam logic signed [ANGLE_W-1:0] HALF_PI_Q13 = 16'sd12868;

    localparam int K_Q16 = 39797;

    localparam logic signed [ANGLE_W-1:0] ATAN_LUT [0:13] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128,
        16'sd64,   16'sd32,   16'sd16,   16'sd8,    16'sd4,   16'sd2,   16'sd1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_ITER  = 2'd2,
        ST_SCALE = 2'd3
    } state_t;

    // Clamp an incoming phase to [-pi, +pi] so the quadrant fold stays valid.
    function automatic logic signed [ANGLE_W-1:0] sat_angle(input logic signed [ANGLE_W-1:0] a);
        if (a > PI_Q13)
            return PI_Q13;
        else if (a < -PI_Q13)
            return -PI_Q13;
        else
            return a;
    endfunction

endpackage

// File: rtl/polar_to_rect_rot_step.sv
// One combinational CORDIC rotation-mode micro-step with a run-time shift amount.
module cordic_rot_step
    import polar_pkg::*;
#(
    parameter int XW = 15
) (
    input  logic signed [XW-1:0]      i_x,
    input  logic signed [XW-1:0]      i_y,
    input  logic signed [ANGLE_W-1:0] i_z,
    input  logic        [3:0]         i_shift,
    output logic signed [XW-1:0]      o_x,
    output logic signed [XW-1:0]      o_y,
    output logic signed [ANGLE_W-1:0] o_z
);

    logic signed [XW-1:0]      w_xs;
    logic signed [XW-1:0]      w_ys;
    logic signed [ANGLE_W-1:0] w_atan;
    logic                      w_neg;

    assign w_xs  = i_x >>> i_shift;
    assign w_ys  = i_y >>> i_shift;
    assign w_neg = i_z[ANGLE_W-1];

    // Table lookup; shift values past the table end never occur for legal ITER.
    always_comb begin
        w_atan = '0;
        if (i_shift <= 4'd13)
            w_atan = ATAN_LUT[i_shift];
    end

    // Rotate toward z = 0: d = +1 for non-negative z, -1 otherwise.
    always_comb begin
        if (w_neg) begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + w_atan;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - w_atan;
        end
    end

endmodule

// File: rtl/polar_to_rect.sv
// Iterative rotation-mode CORDIC: (magnitude, phase) -> (real, imag).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | ready; capture abs and saturated phase on val_i
//  ST_PRE   | quadrant fold into +-pi/2, load x/y with guard bits
//  ST_ITER  | ITER micro-rotations through the shared rot step
//  ST_SCALE | gain compensation, saturate, register outputs, pulse val_o
module polar_to_rect
    import polar_pkg::*;
#(
    parameter int ITER = 12,
    parameter int GW   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic        [ABS_W-1:0]   abs_i,
    input  logic signed [ANGLE_W-1:0] angle_i,
    input  logic                      val_i,
    output logic                      rdy_o,
    output logic signed [OUT_W-1:0]   real_o,
    output logic signed [OUT_W-1:0]   imag_o,
    output logic                      val_o
);

    localparam int XW = 11 + GW;
    localparam int PW = XW + 17;
    localparam logic signed [PW-1:0] K_EXT = PW'(K_Q16);
    localparam logic signed [PW-1:0] RND   = PW'(1) <<< (15 + GW - 1);
    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    state_t                    r_state;
    logic        [ABS_W-1:0]   r_abs;
    logic signed [XW-1:0]      r_x;
    logic signed [XW-1:0]      r_y;
    logic signed [ANGLE_W-1:0] r_z;
    logic        [3:0]         r_iter;
    logic                      r_rdy;
    logic                      r_val;
    logic signed [OUT_W-1:0]   r_real;
    logic signed [OUT_W-1:0]   r_imag;

    logic signed [XW-1:0]      w_x_n;
    logic signed [XW-1:0]      w_y_n;
    logic signed [ANGLE_W-1:0] w_z_n;
    logic signed [XW-1:0]      w_abs_sh;
    logic signed [PW-1:0]      w_px;
    logic signed [PW-1:0]      w_py;

    cordic_rot_step #(.XW(XW)) u_step (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_iter),
        .o_x     (w_x_n),
        .o_y     (w_y_n),
        .o_z     (w_z_n)
    );

    assign w_abs_sh = $signed({{(XW-ABS_W){1'b0}}, r_abs}) <<< GW;
    assign w_px     = ($signed({{17{r_x[XW-1]}}, r_x}) * K_EXT + RND) >>> (16 + GW);
    assign w_py     = ($signed({{17{r_y[XW-1]}}, r_y}) * K_EXT + RND) >>> (16 + GW);

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PW-1:0] v);
        if (v > PW'(255))
            return 9'sd255;
        else if (v < -PW'(256))
            return -9'sd256;
        else
            return v[OUT_W-1:0];
    endfunction

    // Sequencer and datapath registers; reset discards any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_abs   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_rdy   <= 1'b1;
            r_val   <= 1'b0;
            r_real  <= '0;
            r_imag  <= '0;
        end else begin
            r_val <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (val_i) begin
                        r_abs   <= abs_i;
                        r_z     <= sat_angle(angle_i);
                        r_rdy   <= 1'b0;
                        r_state <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (r_z > HALF_PI_Q13) begin
                        r_x <= '0;
                        r_y <= w_abs_sh;
                        r_z <= r_z - HALF_PI_Q13;
                    end else if (r_z < -HALF_PI_Q13) begin
                        r_x <= '0;
                        r_y <= -w_abs_sh;
                        r_z <= r_z + HALF_PI_Q13;
                    end else begin
                        r_x <= w_abs_sh;
                        r_y <= '0;
                    end
                    r_iter  <= '0;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    r_x    <= w_x_n;
                    r_y    <= w_y_n;
                    r_z    <= w_z_n;
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == LAST_ITER)
                        r_state <= ST_SCALE;
                end
                ST_SCALE: begin
                    r_real  <= sat_out(w_px);
                    r_imag  <= sat_out(w_py);
                    r_val   <= 1'b1;
                    r_rdy   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign rdy_o  = r_rdy;
    assign val_o  = r_val;
    assign real_o = r_real;
    assign imag_o = r_imag;

endmodule

// File: tb/tb_polar_to_rect.sv
// Scoreboard bench for polar_to_rect against a floating-point reference.
module tb_polar_to_rect;

    logic               clk = 1'b0;
    logic               rst;
    logic        [7:0]  abs_i;
    logic signed [15:0] angle_i;
    logic               val_i;
    logic               rdy_o;
    logic signed [8:0]  real_o;
    logic signed [8:0]  imag_o;
    logic               val_o;

    polar_to_rect #(.ITER(12), .GW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .abs_i   (abs_i),
        .angle_i (angle_i),
        .val_i   (val_i),
        .rdy_o   (rdy_o),
        .real_o  (real_o),
        .imag_o  (imag_o),
        .val_o   (val_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int tol;
        int t;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   stream_mode = 1'b0;
    int   out_cycs[$];
    bit   prev_val = 1'b0;
    int   val_cnt  = 0;
    bit   rt_mode  = 1'b0;
    int   rt_re, rt_im;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input int a, input int ang);
        exp_t e;
        real  rad;
        int   angc;
        angc = (ang > 25736) ? 25736 : ((ang < -25736) ? -25736 : ang);
        rad  = real'(angc) / 8192.0;
        e.re  = int'(real'(a) * $cos(rad));
        e.im  = int'(real'(a) * $sin(rad));
        e.tol = (a == 0) ? 0 : 2;
        e.t   = 0;
        return e;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Record accepted samples; a reset edge drops everything in flight.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
        end else if (val_i && rdy_o) begin
            if (rt_mode) begin
                e.re  = rt_re;
                e.im  = rt_im;
                e.tol = 3;
            end else begin
                e = model(int'(abs_i), int'(angle_i));
            end
            e.t = cyc;
            q.push_back(e);
        end
        if (cyc > 30000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit 30000", cyc);
            $fatal(1, "watchdog");
        end
    end

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && val_o) begin
            val_cnt++;
            chk(rdy_o == 1'b1, "rdy_in_val_cycle", int'(rdy_o), 1);
            chk(prev_val == 1'b0, "val_single_pulse", int'(prev_val), 0);
            if (stream_mode)
                out_cycs.push_back(cyc);
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_output", int'(real_o), 0);
            end else begin
                e = q.pop_front();
                chk(iabs(int'(real_o) - e.re) <= e.tol, "real", int'(real_o), e.re);
                chk(iabs(int'(imag_o) - e.im) <= e.tol, "imag", int'(imag_o), e.im);
                chk(cyc - e.t == 14, "latency", cyc - e.t, 14);
            end
        end
        prev_val = val_o;
    end

    task automatic send(input int a, input int ang);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            chk(1'b0, "rdy_timeout", n, 100);
        abs_i   = 8'(a);
        angle_i = 16'(ang);
        val_i   = 1'b1;
        @(posedge clk);
        #1 val_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            chk(1'b0, "drain_timeout", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk(rdy_o == 1'b1, {tag, "_rdy"}, int'(rdy_o), 1);
        chk(val_o == 1'b0, {tag, "_val"}, int'(val_o), 0);
        chk(real_o == 9'sd0, {tag, "_real"}, int'(real_o), 0);
        chk(imag_o == 9'sd0, {tag, "_imag"}, int'(imag_o), 0);
    endtask

    initial begin
        int base_cnt;
        int re, im, a, ang;
        real mag;

        rst = 1'b1; val_i = 1'b0; abs_i = '0; angle_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Directed corners: axes, fold, negative quadrant, pi/4, zero, saturation.
        send(100, 0);
        send(100, 12868);
        send(100, -25736);
        send(255, 6434);
        send(0, 12345);
        send(0, -20000);
        send(200, 32767);
        send(200, -32768);
        send(37, 12869);
        send(37, -12869);
        drain();

        // Random polar samples.
        for (int k = 0; k < 40; k++)
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)) - 32768);
        drain();

        // Continuous val_i with fresh data every cycle.
        stream_mode = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            val_i   = 1'b1;
            abs_i   = 8'($urandom_range(0, 255));
            angle_i = 16'($urandom_range(0, 65535));
        end
        @(posedge clk);
        #1 val_i = 1'b0;
        drain();
        stream_mode = 1'b0;
        chk(out_cycs.size() >= 6, "stream_count", out_cycs.size(), 6);
        for (int k = 1; k < out_cycs.size(); k++)
            chk(out_cycs[k] - out_cycs[k-1] == 15, "stream_spacing", out_cycs[k] - out_cycs[k-1], 15);

        // Reset in the middle of the micro-rotations.
        send(150, 3000);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        val_i = 1'b1; abs_i = 8'd90; angle_i = 16'sd100;
        @(posedge clk);
        #1 rst = 1'b0; val_i = 1'b0;
        base_cnt = val_cnt;
        check_reset_state("midreset");
        repeat (30) @(negedge clk);
        chk(val_cnt == base_cnt, "no_stale_output", val_cnt - base_cnt, 0);
        send(120, -7000);
        drain();

        // Round trip from rectangular values through an ideal polar conversion.
        for (int k = 0; k < 30; k++) begin
            do begin
                re  = int'($urandom_range(0, 360)) - 180;
                im  = int'($urandom_range(0, 360)) - 180;
                mag = $sqrt(real'(re * re + im * im));
            end while (mag > 254.0);
            a   = int'(mag);
            ang = int'($atan2(real'(im), real'(re)) * 8192.0);
            if (ang > 25736) ang = 25736;
            if (ang < -25736) ang = -25736;
            rt_re = re;
            rt_im = im;
            rt_mode = 1'b1;
            send(a, ang);
            rt_mode = 1'b0;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
